// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Provides depth/count-width helpers and the read-mode selector values.
package sync_fifo_param_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int unsigned MODE_REGISTERED = 0;
  localparam int unsigned MODE_FWFT       = 1;

  // Default geometry and the occupancy-count width that goes with it.
  localparam int unsigned DEFAULT_ADDR_WIDTH  = 3;
  localparam int unsigned DEFAULT_COUNT_WIDTH = DEFAULT_ADDR_WIDTH + 1;

  // Number of storage entries addressed by a pointer of the given width.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Count must represent 0..DEPTH inclusive, so it needs one extra bit.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and flag control for sync_fifo_param.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   write_enable_i          write request
//   read_enable_i           read request
//   wr_ok_o, rd_ok_o        accepted write/read this cycle
//   wr_ptr_o, rd_ptr_o      storage write/read addresses
//   count_o                 occupancy 0..DEPTH
//   full_o, empty_o         occupancy extremes
//   almost_full_o/empty_o   programmable threshold flags
//   overflow_o, underflow_o one-cycle pulses for rejected requests
module sync_fifo_ctrl
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_THRESH  = 6,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_enable_i,
  input  logic                  read_enable_i,
  output logic                  wr_ok_o,
  output logic                  rd_ok_o,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned CountWidth = count_width(ADDR_WIDTH);
  localparam logic [CountWidth-1:0] DepthCount = CountWidth'(fifo_depth(ADDR_WIDTH));
  localparam logic [CountWidth-1:0] AfCount    = CountWidth'(AF_THRESH);
  localparam logic [CountWidth-1:0] AeCount    = CountWidth'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  wr_ok, rd_ok, full, empty;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DepthCount);
    rd_ok = read_enable_i & ~empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    wr_ok = write_enable_i & (~full | rd_ok);
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // Pointers wrap modulo DEPTH by natural overflow; count disambiguates full/empty.
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      overflow_q  <= write_enable_i & ~wr_ok;
      underflow_q <= read_enable_i & ~rd_ok;
    end
  end

  assign wr_ok_o        = wr_ok;
  assign rd_ok_o        = rd_ok;
  assign wr_ptr_o       = wr_ptr_q;
  assign rd_ptr_o       = rd_ptr_q;
  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AfCount);
  assign almost_empty_o = (count_q <= AeCount);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO: storage array plus read-data path.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   write_data, write_enable     enqueue data / request
//   read_enable                  dequeue request
//   read_data, read_valid        output word and its qualifier
//   full, empty                  occupancy extremes
//   almost_full, almost_empty    programmable threshold flags
//   count                        occupancy 0..DEPTH
//   overflow, underflow          one-cycle pulses for rejected requests
// FWFT selects registered (1-cycle latency) or first-word-fall-through reads.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_THRESH  = 6,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned FWFT       = MODE_REGISTERED
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] write_data,
  input  logic                         write_enable,
  input  logic                         read_enable,
  output logic signed [DATA_WIDTH-1:0] read_data,
  output logic                         read_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [ADDR_WIDTH:0]          count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);

  logic                  wr_ok, rd_ok;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  sync_fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH)
  ) u_ctrl (
    .clk_i          (clk),
    .rst_i          (rst),
    .write_enable_i (write_enable),
    .read_enable_i  (read_enable),
    .wr_ok_o        (wr_ok),
    .rd_ok_o        (rd_ok),
    .wr_ptr_o       (wr_ptr),
    .rd_ptr_o       (rd_ptr),
    .count_o        (count),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_ptr] <= write_data;
    end
  end

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head entry is presented directly; an empty FIFO drives zero.
    assign read_data  = empty ? '0 : mem_q[rd_ptr];
    assign read_valid = ~empty;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        read_data_q  <= '0;
        read_valid_q <= 1'b0;
      end else begin
        read_valid_q <= rd_ok;
        // read_data holds its last value when no read is accepted.
        if (rd_ok) read_data_q <= mem_q[rd_ptr];
      end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a registered-read FIFO and an FWFT FIFO driven in lockstep.
module tb_sync_fifo_param;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] write_data = '0;
  logic              write_enable = 1'b0;
  logic              read_enable = 1'b0;

  logic signed [7:0] rd0, rd1;
  logic              rv0, rv1;
  logic              full0, empty0, af0, ae0, ovf0, unf0;
  logic              full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0]        cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.FWFT(0)) dut_reg (
    .clk (clk), .rst (rst), .write_data (write_data), .write_enable (write_enable),
    .read_enable (read_enable), .read_data (rd0), .read_valid (rv0), .full (full0),
    .empty (empty0), .almost_full (af0), .almost_empty (ae0), .count (cnt0),
    .overflow (ovf0), .underflow (unf0)
  );

  sync_fifo_param #(.FWFT(1)) dut_fwft (
    .clk (clk), .rst (rst), .write_data (write_data), .write_enable (write_enable),
    .read_enable (read_enable), .read_data (rd1), .read_valid (rv1), .full (full1),
    .empty (empty1), .almost_full (af1), .almost_empty (ae1), .count (cnt1),
    .overflow (ovf1), .underflow (unf1)
  );

  // Apply one cycle of requests; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic we, input logic [7:0] wd, input logic re);
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (cnt0 !== 4'd5 || rd0 !== 8'sh10) begin
      n_err++;
      $display("FAIL pre_reset count=%0d data=%h want 5/10", cnt0, rd0);
    end
    // Requests during reset must be ignored.
    rst = 1'b1;
    drive(1'b1, 8'h77, 1'b1);
    rst = 1'b0;
    n_cmp++;
    if (cnt0 !== 4'd0) begin
      n_err++; $display("FAIL reset_count got %0d want 0", cnt0);
    end
    n_cmp++;
    if ({empty0, ae0, full0, af0} !== 4'b1100) begin
      n_err++; $display("FAIL reset_flags got %b want 1100", {empty0, ae0, full0, af0});
    end
    n_cmp++;
    if (rv0 !== 1'b0 || rd0 !== 8'sh00) begin
      n_err++; $display("FAIL reset_read got v=%b d=%h want 0/00", rv0, rd0);
    end
    n_cmp++;
    if (rv1 !== 1'b0 || rd1 !== 8'sh00) begin
      n_err++; $display("FAIL reset_fwft_read got v=%b d=%h want 0/00", rv1, rd1);
    end
  endtask

  task automatic test_registered_read();
    logic [7:0] exp [3];
    exp[0] = 8'h05; exp[1] = 8'hFD; exp[2] = 8'h7F;
    for (int i = 0; i < 3; i++) drive(1'b1, exp[i], 1'b0);
    n_cmp++;
    if (rv1 !== 1'b1 || rd1 !== 8'sh05) begin
      n_err++; $display("FAIL fwft_head got v=%b d=%h want 1/05", rv1, rd1);
    end
    n_cmp++;
    if (rv0 !== 1'b0) begin
      n_err++; $display("FAIL reg_valid_idle got %b want 0", rv0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (rv0 !== 1'b1 || rd0 !== exp[i]) begin
        n_err++; $display("FAIL reg_read%0d got v=%b d=%h want 1/%h", i, rv0, rd0, exp[i]);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (rv0 !== 1'b0 || rd0 !== 8'sh7F || empty0 !== 1'b1) begin
      n_err++;
      $display("FAIL reg_after got v=%b d=%h e=%b want 0/7f/1", rv0, rd0, empty0);
    end
  endtask

  task automatic test_fill_overflow();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'(8'hA0 + k), 1'b0);
      n_cmp++;
      if (cnt0 !== 4'(k) || af0 !== (k >= 6) || full0 !== (k == 8) || ae0 !== (k <= 2)) begin
        n_err++;
        $display("FAIL fill%0d got c=%0d af=%b f=%b ae=%b", k, cnt0, af0, full0, ae0);
      end
    end
    drive(1'b1, 8'hFF, 1'b0);
    n_cmp++;
    if (ovf0 !== 1'b1 || cnt0 !== 4'd8) begin
      n_err++; $display("FAIL overflow got o=%b c=%0d want 1/8", ovf0, cnt0);
    end
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (ovf0 !== 1'b0) begin
      n_err++; $display("FAIL overflow_pulse got %b want 0", ovf0);
    end
  endtask

  task automatic test_full_read_write();
    logic [7:0] exp;
    drive(1'b1, 8'h55, 1'b1);
    n_cmp++;
    if (cnt0 !== 4'd8 || ovf0 !== 1'b0 || rd0 !== 8'shA1) begin
      n_err++;
      $display("FAIL full_rw got c=%0d o=%b d=%h want 8/0/a1", cnt0, ovf0, rd0);
    end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 8'h55 : 8'(8'hA2 + i);
      drive(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (rd0 !== exp) begin
        n_err++; $display("FAIL drain%0d got %h want %h", i, rd0, exp);
      end
    end
    n_cmp++;
    if (empty0 !== 1'b1 || unf0 !== 1'b0) begin
      n_err++; $display("FAIL drained got e=%b u=%b want 1/0", empty0, unf0);
    end
  endtask

  task automatic test_empty_read_write();
    drive(1'b1, 8'h11, 1'b1);
    n_cmp++;
    if (unf0 !== 1'b1 || cnt0 !== 4'd1 || rv0 !== 1'b0) begin
      n_err++;
      $display("FAIL empty_rw got u=%b c=%0d v=%b want 1/1/0", unf0, cnt0, rv0);
    end
    n_cmp++;
    if (rv1 !== 1'b1 || rd1 !== 8'sh11) begin
      n_err++; $display("FAIL empty_rw_fwft got v=%b d=%h want 1/11", rv1, rd1);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (unf0 !== 1'b0 || rd0 !== 8'sh11 || cnt0 !== 4'd0 || rv1 !== 1'b0 || rd1 !== 8'sh00) begin
      n_err++;
      $display("FAIL empty_pop got u=%b d=%h c=%0d fv=%b fd=%h", unf0, rd0, cnt0, rv1, rd1);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] val;
    for (int i = 0; i < 20; i++) begin
      val = 8'(8'h30 + i);
      drive(1'b1, val, 1'b0);
      n_cmp++;
      if (cnt0 !== 4'd1 || rd1 !== val) begin
        n_err++; $display("FAIL wrap_wr%0d got c=%0d fd=%h want 1/%h", i, cnt0, rd1, val);
      end
      drive(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (rd0 !== val || cnt0 !== 4'd0) begin
        n_err++; $display("FAIL wrap_rd%0d got d=%h c=%0d want %h/0", i, rd0, cnt0, val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_registered_read();
    test_fill_overflow();
    test_full_read_write();
    test_empty_read_write();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
